// File: rtl/servo_pkg.sv
// rtl/servo_pkg.sv - shared constants and rx state encoding for the servo instruction path
package servo_pkg;

   localparam int INSTR_WIDTH = 10;

   // Opcode field, instruction bits [9:8]
   localparam logic [1:0] OP_IDLE      = 2'b00;
   localparam logic [1:0] OP_TURNTABLE = 2'b01;
   localparam logic [1:0] OP_EXTEND    = 2'b10;
   localparam logic [1:0] OP_RETRACT   = 2'b11;

   // Receiver states; the encoding doubles as the debug LED value
   typedef enum logic [1:0] {
      COUNT     = 2'd0,
      RECEIVE   = 2'd1,
      CONFIRMED = 2'd2,
      COMPLETE  = 2'd3
   } rx_state_t;

endpackage

// File: rtl/sync_ff.sv
// rtl/sync_ff.sv - parameterised-depth single-bit synchroniser with asynchronous reset
module sync_ff #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] chain;

   // Shift the asynchronous input through STAGES flops to settle metastability
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         chain <= '0;
      end else begin
         chain[0] <= d;
         for (int i = 1; i < STAGES; i++) begin
            chain[i] <= chain[i-1];
         end
      end
   end

   assign q = chain[STAGES-1];

endmodule

// File: rtl/serial_instr_rx.sv
// rtl/serial_instr_rx.sv - bit-serial handshake receiver assembling servo instructions
module serial_instr_rx #(
   parameter int INSTR_WIDTH    = servo_pkg::INSTR_WIDTH,
   parameter int TIMEOUT_CYCLES = 240000,
   parameter int SYNC_STAGES    = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   data_ready,
   input  logic                   data_bit,
   input  logic                   instr_clear,
   output logic                   data_ack,
   output logic [INSTR_WIDTH-1:0] servo_instr,
   output logic                   instruction_ready,
   output logic                   frame_error,
   output logic [1:0]             instr_state
);

   localparam int CW = $clog2(INSTR_WIDTH + 1);
   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] FRAME_BITS = CW'(INSTR_WIDTH);
   localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYCLES - 1);

   servo_pkg::rx_state_t state, state_nxt;

   logic                   rdy_s, bit_s, rdy_q;
   logic                   rdy_rise, rdy_fall, rdy_edge;
   logic [INSTR_WIDTH-1:0] shift_reg, shift_nxt;
   logic [INSTR_WIDTH-1:0] instr_nxt;
   logic [CW-1:0]          bit_cnt, cnt_nxt;
   logic [TW-1:0]          tmo_cnt;
   logic                   tmo_active, tmo_expired;
   logic                   ack_nxt, ready_nxt, err_nxt;

   sync_ff #(.STAGES(SYNC_STAGES)) u_sync_rdy (
      .clk   (clk),
      .reset (reset),
      .d     (data_ready),
      .q     (rdy_s)
   );

   sync_ff #(.STAGES(SYNC_STAGES)) u_sync_bit (
      .clk   (clk),
      .reset (reset),
      .d     (data_bit),
      .q     (bit_s)
   );

   // Delayed copy of the synchronised strobe for edge detection
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rdy_q <= 1'b0;
      end else begin
         rdy_q <= rdy_s;
      end
   end

   assign rdy_rise = rdy_s & ~rdy_q;
   assign rdy_fall = ~rdy_s & rdy_q;
   assign rdy_edge = rdy_rise | rdy_fall;

   // Idle COUNT with no bits gathered must never time out; a strobe edge beats expiry
   assign tmo_active  = (bit_cnt != '0) || (state == servo_pkg::RECEIVE);
   assign tmo_expired = tmo_active && !rdy_edge && (tmo_cnt == TMO_LAST);

   // Stall counter: restarts on every strobe edge, parked at zero while idle
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tmo_cnt <= '0;
      end else if (rdy_edge || !tmo_active || tmo_expired) begin
         tmo_cnt <= '0;
      end else begin
         tmo_cnt <= tmo_cnt + TW'(1);
      end
   end

   // Handshake state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= servo_pkg::COUNT;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and datapath decisions; an abort overrides the normal handshake flow
   always_comb begin
      state_nxt = state;
      shift_nxt = shift_reg;
      cnt_nxt   = bit_cnt;
      ack_nxt   = data_ack;
      instr_nxt = servo_instr;
      ready_nxt = instruction_ready;
      err_nxt   = 1'b0;

      if (instr_clear) begin
         ready_nxt = 1'b0;
      end

      if (tmo_expired) begin
         ack_nxt   = 1'b0;
         cnt_nxt   = '0;
         err_nxt   = 1'b1;
         state_nxt = servo_pkg::COUNT;
      end else begin
         case (state)
            servo_pkg::COUNT: begin
               if (rdy_rise) begin
                  shift_nxt = {shift_reg[INSTR_WIDTH-2:0], bit_s};
                  cnt_nxt   = bit_cnt + CW'(1);
                  ack_nxt   = 1'b1;
                  state_nxt = servo_pkg::RECEIVE;
                  // First bit of a new frame retires the previous instruction
                  if (bit_cnt == '0) begin
                     ready_nxt = 1'b0;
                  end
               end
            end
            servo_pkg::RECEIVE: begin
               if (rdy_fall) begin
                  ack_nxt   = 1'b0;
                  state_nxt = servo_pkg::CONFIRMED;
               end
            end
            servo_pkg::CONFIRMED: begin
               state_nxt = (bit_cnt == FRAME_BITS) ? servo_pkg::COMPLETE : servo_pkg::COUNT;
            end
            servo_pkg::COMPLETE: begin
               // Completion wins over a simultaneous instr_clear
               instr_nxt = shift_reg;
               ready_nxt = 1'b1;
               cnt_nxt   = '0;
               state_nxt = servo_pkg::COUNT;
            end
            default: begin
               state_nxt = servo_pkg::COUNT;
            end
         endcase
      end
   end

   // Datapath and output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shift_reg         <= '0;
         bit_cnt           <= '0;
         data_ack          <= 1'b0;
         servo_instr       <= '0;
         instruction_ready <= 1'b0;
         frame_error       <= 1'b0;
      end else begin
         shift_reg         <= shift_nxt;
         bit_cnt           <= cnt_nxt;
         data_ack          <= ack_nxt;
         servo_instr       <= instr_nxt;
         instruction_ready <= ready_nxt;
         frame_error       <= err_nxt;
      end
   end

   assign instr_state = state;

endmodule

// File: tb/tb_serial_instr_rx.sv
// tb/tb_serial_instr_rx.sv - directed self-checking bench for serial_instr_rx
module tb_serial_instr_rx;

   localparam int W   = 10;
   localparam int TMO = 100;

   logic         clk = 1'b0;
   logic         reset;
   logic         data_ready;
   logic         data_bit;
   logic         instr_clear;
   logic         data_ack;
   logic [W-1:0] servo_instr;
   logic         instruction_ready;
   logic         frame_error;
   logic [1:0]   instr_state;

   int total  = 0;
   int passed = 0;
   int fails  = 0;
   int ack_rises = 0;
   logic ack_prev = 1'b0;

   serial_instr_rx #(
      .INSTR_WIDTH    (W),
      .TIMEOUT_CYCLES (TMO),
      .SYNC_STAGES    (2)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .data_ready        (data_ready),
      .data_bit          (data_bit),
      .instr_clear       (instr_clear),
      .data_ack          (data_ack),
      .servo_instr       (servo_instr),
      .instruction_ready (instruction_ready),
      .frame_error       (frame_error),
      .instr_state       (instr_state)
   );

   always #5 clk = ~clk;

   // Count rising edges of the acknowledge
   always @(negedge clk) begin
      if (data_ack && !ack_prev) ack_rises++;
      ack_prev = data_ack;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One four-phase handshake; returns tail cycles after the ack-low check
   task automatic send_bit(input logic b, input int ph, input int tail);
      data_bit = b;
      cyc(1);
      data_ready = 1'b1;
      cyc(2);
      chk("ack_before_rise", {31'b0, data_ack}, 32'd0);
      cyc(1);
      chk("ack_after_rise", {31'b0, data_ack}, 32'd1);
      cyc(ph - 3);
      data_ready = 1'b0;
      cyc(2);
      chk("ack_before_fall", {31'b0, data_ack}, 32'd1);
      cyc(1);
      chk("ack_after_fall", {31'b0, data_ack}, 32'd0);
      cyc(tail);
   endtask

   task automatic send_frame(input logic [W-1:0] v);
      for (int i = W - 1; i >= 0; i--) send_bit(v[i], 20, 17);
   endtask

   initial begin
      logic [W-1:0] v;
      int start_rises;

      reset       = 1'b1;
      data_ready  = 1'b0;
      data_bit    = 1'b0;
      instr_clear = 1'b0;
      cyc(3);
      chk("rst_ack",   {31'b0, data_ack}, 32'd0);
      chk("rst_instr", {22'b0, servo_instr}, 32'd0);
      chk("rst_ready", {31'b0, instruction_ready}, 32'd0);
      chk("rst_err",   {31'b0, frame_error}, 32'd0);
      chk("rst_state", {30'b0, instr_state}, 32'd0);
      reset = 1'b0;
      cyc(3);

      // Single frame with exact completion latency
      v = 10'h180;
      start_rises = ack_rises;
      for (int i = W - 1; i >= 1; i--) send_bit(v[i], 20, 17);
      send_bit(v[0], 20, 0);
      chk("sf_confirmed", {30'b0, instr_state}, 32'd2);
      cyc(1);
      chk("sf_complete", {30'b0, instr_state}, 32'd3);
      chk("sf_ready_m2", {31'b0, instruction_ready}, 32'd0);
      cyc(1);
      chk("sf_ready_m3", {31'b0, instruction_ready}, 32'd1);
      chk("sf_instr",    {22'b0, servo_instr}, 32'h180);
      chk("sf_idle",     {30'b0, instr_state}, 32'd0);
      chk("sf_ack_cnt",  ack_rises - start_rises, 32'd10);
      cyc(10);

      // Back-to-back frames
      send_frame(10'h3FF);
      chk("b2b_instr1", {22'b0, servo_instr}, 32'h3FF);
      chk("b2b_ready1", {31'b0, instruction_ready}, 32'd1);
      send_bit(1'b0, 20, 17);
      chk("b2b_ready_drop", {31'b0, instruction_ready}, 32'd0);
      chk("b2b_hold1", {22'b0, servo_instr}, 32'h3FF);
      for (int i = 8; i >= 1; i--) send_bit(1'b0, 20, 17);
      chk("b2b_hold9", {22'b0, servo_instr}, 32'h3FF);
      send_bit(1'b0, 20, 17);
      chk("b2b_instr2", {22'b0, servo_instr}, 32'h000);
      chk("b2b_ready2", {31'b0, instruction_ready}, 32'd1);

      // Timeout after four bits
      send_bit(1'b1, 20, 17);
      send_bit(1'b0, 20, 17);
      send_bit(1'b1, 20, 17);
      send_bit(1'b1, 20, 0);
      cyc(TMO - 1);
      chk("to_err_early", {31'b0, frame_error}, 32'd0);
      chk("to_cnt_early", {28'b0, dut.bit_cnt}, 32'd4);
      cyc(1);
      chk("to_err_pulse", {31'b0, frame_error}, 32'd1);
      chk("to_cnt_clear", {28'b0, dut.bit_cnt}, 32'd0);
      chk("to_instr_kept", {22'b0, servo_instr}, 32'h000);
      chk("to_ready_kept", {31'b0, instruction_ready}, 32'd0);
      cyc(1);
      chk("to_err_one_cycle", {31'b0, frame_error}, 32'd0);
      cyc(5);
      send_frame(10'h2AA);
      chk("to_next_instr", {22'b0, servo_instr}, 32'h2AA);
      chk("to_next_ready", {31'b0, instruction_ready}, 32'd1);

      // Strobe stuck high mid-frame
      send_bit(1'b1, 20, 17);
      send_bit(1'b1, 20, 17);
      send_bit(1'b0, 20, 17);
      data_bit = 1'b1;
      cyc(1);
      data_ready = 1'b1;
      cyc(3);
      chk("st_ack_high", {31'b0, data_ack}, 32'd1);
      chk("st_cnt4", {28'b0, dut.bit_cnt}, 32'd4);
      cyc(TMO - 1);
      chk("st_ack_before_to", {31'b0, data_ack}, 32'd1);
      cyc(1);
      chk("st_ack_to", {31'b0, data_ack}, 32'd0);
      chk("st_err", {31'b0, frame_error}, 32'd1);
      chk("st_cnt_clear", {28'b0, dut.bit_cnt}, 32'd0);
      cyc(200 - 3 - TMO);
      chk("st_no_retrigger_cnt", {28'b0, dut.bit_cnt}, 32'd0);
      chk("st_no_retrigger_ack", {31'b0, data_ack}, 32'd0);
      data_ready = 1'b0;
      cyc(20);
      chk("st_fall_ignored", {28'b0, dut.bit_cnt}, 32'd0);
      chk("st_instr_kept", {22'b0, servo_instr}, 32'h2AA);
      send_frame(10'h0F3);
      chk("st_next_instr", {22'b0, servo_instr}, 32'h0F3);

      // Asynchronous reset mid-frame, with the acknowledge high
      v = 10'h2AA;
      for (int i = W - 1; i >= W - 5; i--) send_bit(v[i], 20, 17);
      data_bit = 1'b1;
      cyc(1);
      data_ready = 1'b1;
      cyc(3);
      chk("rm_ack_high", {31'b0, data_ack}, 32'd1);
      reset = 1'b1;
      #1;
      chk("rm_ack",   {31'b0, data_ack}, 32'd0);
      chk("rm_instr", {22'b0, servo_instr}, 32'd0);
      chk("rm_ready", {31'b0, instruction_ready}, 32'd0);
      chk("rm_err",   {31'b0, frame_error}, 32'd0);
      chk("rm_state", {30'b0, instr_state}, 32'd0);
      chk("rm_cnt",   {28'b0, dut.bit_cnt}, 32'd0);
      data_ready = 1'b0;
      cyc(3);
      reset = 1'b0;
      cyc(3);
      send_frame(10'h155);
      chk("rm_next_instr", {22'b0, servo_instr}, 32'h155);
      chk("rm_next_ready", {31'b0, instruction_ready}, 32'd1);

      // instr_clear colliding with COMPLETE
      v = 10'h0C3;
      for (int i = W - 1; i >= 1; i--) send_bit(v[i], 20, 17);
      send_bit(v[0], 20, 0);
      cyc(1);
      chk("cc_complete", {30'b0, instr_state}, 32'd3);
      instr_clear = 1'b1;
      cyc(1);
      instr_clear = 1'b0;
      chk("cc_ready_wins", {31'b0, instruction_ready}, 32'd1);
      chk("cc_instr", {22'b0, servo_instr}, 32'h0C3);
      cyc(5);
      instr_clear = 1'b1;
      cyc(1);
      instr_clear = 1'b0;
      chk("cc_ready_cleared", {31'b0, instruction_ready}, 32'd0);
      chk("cc_instr_kept", {22'b0, servo_instr}, 32'h0C3);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/serial_instr_rx.md
# serial_instr_rx

Bit-serial instruction receiver between the MBED host link and the servo-control state machine. Accepts one bit per four-phase `data_ready`/`data_ack` handshake and assembles bits MSB-first into a 10-bit instruction. On a full frame it presents the instruction on `servo_instr` with `instruction_ready` held high. It aborts stalled frames by timeout, so a dropped handshake can no longer leave a corrupted instruction driving the servos.

## Interface
- `INSTR_WIDTH`, default 10: bits per frame. [9:8] is the opcode, [7:0] the position.
- `TIMEOUT_CYCLES`, default 240000: mid-frame stall limit (10 ms at 24 MHz).
- `SYNC_STAGES`, default 2: synchroniser depth on `data_ready` and `data_bit`.

Ports:
- `clk` in 1: single system clock; everything is clocked on its rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `data_ready` in 1: host strobe, asynchronous to `clk`.
- `data_bit` in 1: host data, asynchronous to `clk`.
- `instr_clear` in 1: consumer pulse; drops `instruction_ready`.
- `data_ack` out 1: per-bit acknowledge to the host.
- `servo_instr` out INSTR_WIDTH: last complete instruction.
- `instruction_ready` out 1: `servo_instr` holds an unconsumed, complete frame.
- `frame_error` out 1: one-cycle pulse when a frame is aborted by timeout.
- `instr_state` out 2: debug LEDs; 0 COUNT, 1 RECEIVE, 2 CONFIRMED, 3 COMPLETE.

## Operation
- **Reset values.** All outputs are 0: `data_ack`, `servo_instr`, `instruction_ready`, `frame_error`, `instr_state`. The shift register and `bit_cnt` are also 0.
- **Synchronisation.** `data_ready` and `data_bit` pass through identical SYNC_STAGES flop chains, giving `rdy_s` and `bit_s`. A registered copy of `rdy_s` provides rise and fall detection.
- **Host rule.** `data_bit` must be stable from before `data_ready` rises until the host sees `data_ack` high.
- **State COUNT.** On a rise of `rdy_s`:
  - shift `bit_s` into the LSB (left shift);
  - increment `bit_cnt`;
  - set `data_ack`=1;
  - go to RECEIVE.
- **State RECEIVE.** On a fall of `rdy_s`: set `data_ack`=0 and go to CONFIRMED.
- **State CONFIRMED.** Lasts one cycle.
  - If `bit_cnt`==INSTR_WIDTH, go to COMPLETE.
  - Otherwise go to COUNT.
- **State COMPLETE.** Lasts one cycle.
  - Load `servo_instr` from the shift register and set `instruction_ready`=1.
  - Clear `bit_cnt` and go to COUNT.
- **Holding the instruction.** `servo_instr` changes only in COMPLETE, so partial frames never appear at the output.
- **Clearing `instruction_ready`.** It drops on `instr_clear`, or when the first bit of the next frame is accepted (`bit_cnt` goes 0→1).
- **Timeout.**
  - The counter is active when `bit_cnt`≠0 or the state is RECEIVE.
  - It restarts on every `rdy_s` edge.
  - On reaching TIMEOUT_CYCLES-1 the block aborts the frame: `data_ack`=0, `bit_cnt`=0, state COUNT, `frame_error` pulses for one cycle.
  - `servo_instr` and `instruction_ready` are untouched by an abort.
  - COUNT with `bit_cnt`=0 is idle and never times out.
- **Stuck-high strobe.** If `rdy_s` is still high after an abort, there is no re-trigger, because COUNT waits for a rising edge.
- **Width rules.** `bit_cnt` is $clog2(INSTR_WIDTH+1) bits wide; the timeout counter is $clog2(TIMEOUT_CYCLES) bits wide.

## Timing
- **Acknowledge latency.** A `data_ready` pin edge reaches `rdy_s` after SYNC_STAGES cycles.
  - A rise edge detected at cycle n gives `data_ack` high from n+1.
  - A fall edge detected at cycle m gives `data_ack` low from m+1.
- **Frame latency.** The last bit's `rdy_s` fall at cycle m puts the state in CONFIRMED at m+1 and COMPLETE at m+2. `servo_instr` and `instruction_ready` are valid from m+3.
- **Minimum host phase.** The host must hold each `data_ready` phase for at least SYNC_STAGES+1 cycles.
- **Simultaneous events:**
  - `instr_clear` in the same cycle as COMPLETE: completion wins, so `instruction_ready`=1.
  - Timeout in the same cycle as an `rdy_s` edge: the edge wins and the counter restarts.
  - `reset` mid-frame: immediate asynchronous clear; the partial frame is discarded.

## Structure
- **Package `servo_pkg`:**
  - INSTR_WIDTH;
  - opcode constants OP_IDLE=2'b00, OP_TURNTABLE=2'b01, OP_EXTEND=2'b10, OP_RETRACT=2'b11;
  - the rx state encoding COUNT/RECEIVE/CONFIRMED/COMPLETE (0..3).
- **Sub-module `sync_ff`:** parameterised-depth synchroniser with asynchronous reset; instantiated twice.

## Test plan
- **Single frame.** Send 10'b01_10000000 with 20-cycle phases. Required: `servo_instr`=10'h180 and `instruction_ready`=1 at fall+3. There must be 10 `data_ack` pulses, each rising one cycle after its `rdy_s` rise.
- **Back-to-back frames.** Send 10'h3FF, then 10'h000. Required:
  - `instruction_ready` drops on the first bit of frame 2;
  - `servo_instr` stays 10'h3FF until frame 2 completes, then reads 10'h000.
- **Timeout.** Use TIMEOUT_CYCLES=100. Send 4 bits, then hold `data_ready` low. Required:
  - `frame_error` pulses for exactly one cycle, 100 cycles after the last edge;
  - `bit_cnt`=0 and `servo_instr` unchanged;
  - a following full frame of 10'h2AA is received correctly.
- **Stuck high.** Hold `data_ready` high for 200 cycles mid-frame. Required: `data_ack` goes 0 at timeout, and no bit is accepted until a fresh rise.
- **Reset mid-frame.** Assert `reset` after bit 5. Required: all outputs 0 asynchronously, and the next frame of 10'h155 decodes correctly.
- **Clear collision.** Pulse `instr_clear` in the COMPLETE cycle. Required: `instruction_ready`=1. A later `instr_clear` drops it to 0 on the next cycle.
